// File: rtl/register_file.sv
// register_file: sixteen 16-bit registers for the tiny16 CPU.
// R0 reads as zero, R1 is PC and R2 is SP; both have dedicated +/-1
// arithmetic. Reads are combinational. All writes commit on the rising
// edge of clk, with a fixed priority between bus writes and PC/SP updates.
module register_file #(
   parameter logic [3:0]  PC_IDX   = 4'd1,
   parameter logic [3:0]  SP_IDX   = 4'd2,
   parameter logic [15:0] SP_RESET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  reg_src_sel,
   input  logic [3:0]  reg_dst_sel,
   input  logic [15:0] bus_in,
   input  logic        reg_in_en,
   input  logic        reg_lo_en,
   input  logic        reg_up_en,
   input  logic        reg_out_en,
   input  logic        reg_pc_inc,
   input  logic        reg_sp_inc,
   input  logic        reg_sp_dec,
   output logic [15:0] bus_out,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [15:0] pc_out,
   output logic [15:0] sp_out,
   input  logic [3:0]  dbg_sel,
   output logic [15:0] dbg_data
);

   // Entry 0 is reset and never written; read_reg also masks it so it
   // reads zero even before the first reset edge.
   logic [15:0] regs [16];

   logic        wr_en;
   logic [15:0] wr_data;

   function automatic logic [15:0] read_reg(input logic [3:0] sel);
      return (sel == 4'd0) ? 16'h0000 : regs[sel];
   endfunction

   // Merge the incoming bus value with the destination's current contents.
   always_comb begin
      // NOTE: assign every output of a combinational block first so no
      // path leaves it unassigned, which would infer a latch.
      wr_en   = reg_in_en | reg_lo_en | reg_up_en;
      wr_data = regs[reg_dst_sel];
      if (reg_in_en) begin
         wr_data = bus_in;
      end else begin
         if (reg_up_en) wr_data[15:8] = bus_in[7:0];
         if (reg_lo_en) wr_data[7:0]  = bus_in[7:0];
      end
   end

   // Commit PC/SP arithmetic, then the bus write; the later write to the
   // same entry wins, which gives bus writes precedence over inc/dec.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, independent of statement order
      // between always blocks.
      if (rst) begin
         // The register file is architectural state the CPU relies on
         // after reset, so every entry is cleared, not just the control regs.
         for (int i = 0; i < 16; i++) begin
            regs[i] <= (4'(i) == SP_IDX) ? SP_RESET : 16'h0000;
         end
      end else begin
         if (reg_pc_inc) begin
            regs[PC_IDX] <= regs[PC_IDX] + 16'd1;
         end
         if (reg_sp_inc && !reg_sp_dec) begin
            regs[SP_IDX] <= regs[SP_IDX] + 16'd1;
         end else if (reg_sp_dec && !reg_sp_inc) begin
            regs[SP_IDX] <= regs[SP_IDX] - 16'd1;
         end
         if (wr_en && (reg_dst_sel != 4'd0)) begin
            regs[reg_dst_sel] <= wr_data;
         end
      end
   end

   // Read ports: plain muxes; bus_out is zeroed when not enabled so it can
   // be OR-combined onto the shared bus.
   always_comb begin
      alu_a    = read_reg(reg_dst_sel);
      alu_b    = read_reg(reg_src_sel);
      bus_out  = reg_out_en ? read_reg(reg_src_sel) : 16'h0000;
      dbg_data = read_reg(dbg_sel);
      pc_out   = read_reg(PC_IDX);
      sp_out   = read_reg(SP_IDX);
   end

endmodule
